gray_sobel: RTL and testbench
=============================

# gray_sobel

Streaming 3x3 Sobel edge filter that sits directly downstream of the Bayer-to-grayscale stage. It consumes the half-resolution 12-bit gray pixel stream (default 640x480), keeps the two previous gray rows in line buffers and computes |Gx|+|Gy| per centre pixel. It emits a saturated 12-bit gradient magnitude, a thresholded edge flag and the centre pixel's coordinates for the downstream edge/overlay stage.

## Interface
- IMG_W, 640, gray pixels per row
- IMG_H, 480, gray rows per frame
- DATA_WIDTH, 12, gray and output pixel width
- THRESH, 12'd256, magnitude at or above which sobel_edge asserts
- clk  input  1  clock; all logic on posedge
- rst  input  1  reset, synchronous, active-high
- gray_pixel  input  DATA_WIDTH  gray sample from upstream
- gray_pixel_valid  input  1  qualifies gray_pixel; arbitrary gaps allowed, no backpressure
- sobel_pixel  output  DATA_WIDTH  gradient magnitude, saturated
- sobel_valid  output  1  one-cycle qualifier for outputs
- sobel_edge  output  1  sobel_pixel >= THRESH
- out_col  output  16  centre column of the emitted result
- out_row  output  16  centre row of the emitted result

## Operation
- col/row counters advance only on gray_pixel_valid. col wraps IMG_W-1 -> 0 and increments row; row wraps IMG_H-1 -> 0. Raster order from reset; there is no frame-sync input.
- Line buffer L0 delays gray_pixel by IMG_W valid samples. L1 delays L0's output by IMG_W valid samples. Both shift only on valid.
- 3x3 window registers shift left on valid. The new right column is {L1 out (top), L0 out (mid), gray_pixel (bottom)}.
- After the input at (r,c) is accepted, the window covers rows r-2..r and cols c-2..c. The centre is (r-1, c-1).
- Result is produced for an accepted input only when r>=1 and c>=1. That gives (IMG_H-1)*(IMG_W-1) results per frame.
- Gx = (p02+2p12+p22) - (p00+2p10+p20), where p[row][col] is window-relative and col 2 is newest. Gy = (p20+2p21+p22) - (p00+2p01+p02).
- Gx and Gy are signed, 15 bits. The magnitude |Gx|+|Gy| is unsigned, 16 bits, maximum 32760. It saturates to 2^DATA_WIDTH-1.
- Border centres force sobel_pixel=0 and sobel_edge=0. A border centre is out_row==0 or out_col==0; the last row and last column are never centres. This masks stale line-buffer and window data from the previous row, frame or reset.
- Line-buffer storage needs no reset. The border masking guarantees that correct data reaches every non-border result.

## Timing
- Reset values: sobel_pixel=0, sobel_valid=0, sobel_edge=0, out_col=0, out_row=0, counters=0, window=0.
- Latency: outputs are registered. sobel_valid is high exactly one cycle after the clk edge that accepts the triggering input.
- Valid gaps: no outputs are produced during gaps. The output sequence is identical to that of a gap-free stream.
- Back-to-back valids give back-to-back sobel_valid pulses.
- Counter wrap and a new valid on the same cycle: the wrap is applied and the pixel is accepted; no sample is dropped.
- rst mid-frame: outputs drop to reset values on the next edge. The next valid is treated as (0,0).
- After a mid-frame reset, the first fully correct non-border result is centre (1,1), reached once rows 0..2 of the new stream are in.
- rst wins over a simultaneous valid; that pixel is discarded.

## Structure
- Shared package `vision_pkg` holds:
  - `gray_t` typedef (logic [11:0]);
  - `grad_t` typedef (signed [14:0]);
  - default frame constants GRAY_W=640 and GRAY_H=480;
  - `sat12` saturation function.
- One sub-module, `line_buffer`: parameters DATA_WIDTH and LENGTH; ports clk, en, in, out. It is a delay line with no reset and is instantiated twice.
- Window, counters, arithmetic and output register live in gray_sobel.

## Test plan
- Flat frame, all pixels 100, continuous valid -> exactly 479*639=306081 sobel_valid pulses; every sobel_pixel=0 and sobel_edge=0.
- Vertical step: col<320 =0, col>=320 =1000 -> centres at cols 319 and 320 (rows 1..478) give sobel_pixel=4000 and edge=1. All other centres give 0. Row 0 and col 0 results are always 0.
- Horizontal step: row<240 =0, row>=240 =4095 -> centres at rows 239 and 240 saturate to 4095 with edge=1. No wrap artefacts appear.
- Upstream-like cadence, valid every other cycle on alternate row-pairs, vertical step stimulus -> output values and order identical to the continuous run. Each sobel_valid lands one cycle after its input valid.
- Threshold boundary, THRESH=256, vertical step of height 64 (magnitude 256) and of height 63 (magnitude 252) -> edge=1 and edge=0 respectively.
- Reset asserted at row 100, col 50, then a fresh vertical-step frame -> outputs are 0 during rst. The first result reports out_row=0 and out_col=0. Results from centre row 1 onward match the golden step frame.

Source files
------------

// File: rtl/vision_pkg.sv
// Shared types and constants for the gray-domain vision stages.
//   gray_t : 12-bit gray sample
//   grad_t : signed 15-bit Sobel gradient component (range +/-16380)
//   GRAY_W / GRAY_H : default half-resolution gray frame size
//   sat12  : clamp an unsigned 16-bit magnitude to the 12-bit pixel range
package vision_pkg;

   typedef logic [11:0] gray_t;
   typedef logic signed [14:0] grad_t;

   localparam int unsigned GRAY_W = 640;
   localparam int unsigned GRAY_H = 480;

   function automatic gray_t sat12(input logic [15:0] mag);
      return (mag > 16'd4095) ? 12'hfff : mag[11:0];
   endfunction

endpackage

// File: rtl/line_buffer.sv
// Delay line: out is the sample written LENGTH enabled cycles earlier.
// No reset; consumers must mask results that depend on unfilled taps.
//   clk : clock
//   en  : shift enable (one accepted sample)
//   in  : sample entering the line
//   out : sample leaving the line (combinational from the last tap)
module line_buffer #(
   parameter int unsigned DATA_WIDTH = 12,
   parameter int unsigned LENGTH     = 640
) (
   input  logic                  clk,
   input  logic                  en,
   input  logic [DATA_WIDTH-1:0] in,
   output logic [DATA_WIDTH-1:0] out
);

   logic [DATA_WIDTH-1:0] taps_q [LENGTH];

   always_ff @(posedge clk) begin
      if (en) begin
         taps_q[0] <= in;
         for (int i = 1; i < LENGTH; i++) begin
            taps_q[i] <= taps_q[i-1];
         end
      end
   end

   assign out = taps_q[LENGTH-1];

endmodule

// File: rtl/gray_sobel.sv
// Streaming 3x3 Sobel filter on the gray pixel stream, |Gx|+|Gy| saturated.
//   clk, rst          : clock, synchronous active-high reset
//   gray_pixel(_valid): raster-order input, gaps allowed, no backpressure
//   sobel_pixel       : saturated gradient magnitude (0 on border centres)
//   sobel_valid       : one-cycle qualifier, one cycle after the accepting edge
//   sobel_edge        : sobel_pixel >= THRESH
//   out_col / out_row : centre coordinates of the emitted result
module gray_sobel
   import vision_pkg::*;
#(
   parameter int unsigned            IMG_W      = GRAY_W,
   parameter int unsigned            IMG_H      = GRAY_H,
   parameter int unsigned            DATA_WIDTH = 12,
   parameter logic [DATA_WIDTH-1:0]  THRESH     = DATA_WIDTH'(256)
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic [DATA_WIDTH-1:0] gray_pixel,
   input  logic                  gray_pixel_valid,
   output logic [DATA_WIDTH-1:0] sobel_pixel,
   output logic                  sobel_valid,
   output logic                  sobel_edge,
   output logic [15:0]           out_col,
   output logic [15:0]           out_row
);

   localparam logic [15:0] ColLast = 16'(IMG_W - 1);
   localparam logic [15:0] RowLast = 16'(IMG_H - 1);

   logic [15:0]           col_q, row_q, col_d, row_d;
   logic [DATA_WIDTH-1:0] win_q [3][3];
   logic [DATA_WIDTH-1:0] new_col [3];
   logic [DATA_WIDTH-1:0] l0_out, l1_out;
   logic                  accept;

   logic [DATA_WIDTH-1:0] pix_q, pix_d;
   logic                  valid_q, edge_q;
   logic [15:0]           ocol_q, orow_q;

   grad_t       p [3][3];
   grad_t       gx, gy;
   logic [14:0] ax, ay;
   logic [15:0] mag;
   logic        emit, border;

   // rst wins over a coincident valid: that sample never enters the line buffers
   assign accept = gray_pixel_valid & ~rst;

   line_buffer #(
      .DATA_WIDTH (DATA_WIDTH),
      .LENGTH     (IMG_W)
   ) u_l0 (
      .clk (clk),
      .en  (accept),
      .in  (gray_pixel),
      .out (l0_out)
   );

   line_buffer #(
      .DATA_WIDTH (DATA_WIDTH),
      .LENGTH     (IMG_W)
   ) u_l1 (
      .clk (clk),
      .en  (accept),
      .in  (l0_out),
      .out (l1_out)
   );

   always_comb begin
      col_d = col_q + 16'd1;
      row_d = row_q;
      if (col_q == ColLast) begin
         col_d = '0;
         row_d = (row_q == RowLast) ? '0 : row_q + 16'd1;
      end
   end

   // Gradient is taken over the post-shift window so the result can be
   // registered on the same edge that accepts the pixel.
   always_comb begin
      new_col[0] = l1_out;
      new_col[1] = l0_out;
      new_col[2] = gray_pixel;
      for (int i = 0; i < 3; i++) begin
         p[i][0] = grad_t'(win_q[i][1]);
         p[i][1] = grad_t'(win_q[i][2]);
         p[i][2] = grad_t'(new_col[i]);
      end
      gx = (p[0][2] + p[1][2] + p[1][2] + p[2][2]) - (p[0][0] + p[1][0] + p[1][0] + p[2][0]);
      gy = (p[2][0] + p[2][1] + p[2][1] + p[2][2]) - (p[0][0] + p[0][1] + p[0][1] + p[0][2]);
      ax = gx[14] ? 15'(-gx) : 15'(gx);
      ay = gy[14] ? 15'(-gy) : 15'(gy);
      mag = 16'(ax) + 16'(ay);
      emit = (row_q != '0) && (col_q != '0);
      // Centre on row 0 or col 0: window holds stale previous-row/frame data
      border = (row_q == 16'd1) || (col_q == 16'd1);
      pix_d = border ? '0 : DATA_WIDTH'(sat12(mag));
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         col_q   <= '0;
         row_q   <= '0;
         valid_q <= 1'b0;
         pix_q   <= '0;
         edge_q  <= 1'b0;
         ocol_q  <= '0;
         orow_q  <= '0;
         for (int i = 0; i < 3; i++) begin
            for (int j = 0; j < 3; j++) begin
               win_q[i][j] <= '0;
            end
         end
      end else if (accept) begin
         col_q   <= col_d;
         row_q   <= row_d;
         valid_q <= emit;
         for (int i = 0; i < 3; i++) begin
            win_q[i][0] <= win_q[i][1];
            win_q[i][1] <= win_q[i][2];
            win_q[i][2] <= new_col[i];
         end
         if (emit) begin
            pix_q  <= pix_d;
            edge_q <= (pix_d >= THRESH);
            ocol_q <= col_q - 16'd1;
            orow_q <= row_q - 16'd1;
         end
      end else begin
         valid_q <= 1'b0;
      end
   end

   assign sobel_pixel = pix_q;
   assign sobel_valid = valid_q;
   assign sobel_edge  = edge_q;
   assign out_col     = ocol_q;
   assign out_row     = orow_q;

endmodule

// File: tb/tb_gray_sobel.sv
// Directed bench for gray_sobel on a reduced 6x5 frame.
module tb_gray_sobel;

   localparam int W = 6;
   localparam int H = 5;

   logic        clk = 1'b0;
   logic        rst;
   logic [11:0] gray_pixel;
   logic        gray_pixel_valid;
   logic [11:0] sobel_pixel;
   logic        sobel_valid;
   logic        sobel_edge;
   logic [15:0] out_col;
   logic [15:0] out_row;

   int total = 0;
   int bad = 0;
   int pulses;

   always #5 clk = ~clk;

   gray_sobel #(
      .IMG_W      (W),
      .IMG_H      (H),
      .DATA_WIDTH (12),
      .THRESH     (12'd256)
   ) dut (
      .clk              (clk),
      .rst              (rst),
      .gray_pixel       (gray_pixel),
      .gray_pixel_valid (gray_pixel_valid),
      .sobel_pixel      (sobel_pixel),
      .sobel_valid      (sobel_valid),
      .sobel_edge       (sobel_edge),
      .out_col          (out_col),
      .out_row          (out_row)
   );

   task automatic check(input string tag, input int got, input int exp);
      total++;
      assert (got === exp) else begin
         bad++;
         $error("FAIL %s observed=%0d expected=%0d", tag, got, exp);
      end
   endtask

   // kind 0: flat h; 1: vertical step at column 'step'; 2: horizontal step at row 'step'
   function automatic int pix_val(input int kind, input int h, input int step,
                                  input int r, input int c);
      if (kind == 1) return (c >= step) ? h : 0;
      if (kind == 2) return (r >= step) ? h : 0;
      return h;
   endfunction

   // Hand-derived step response: the two centres straddling a step of height h
   // see 1+2+1 taps of h on one side only, i.e. 4h; everything else is flat.
   function automatic int exp_mag(input int kind, input int h, input int step,
                                  input int cr, input int cc);
      int m;
      m = 0;
      if (cr == 0 || cc == 0) return 0;
      if (kind == 1 && (cc == step - 1 || cc == step)) m = 4 * h;
      if (kind == 2 && (cr == step - 1 || cr == step)) m = 4 * h;
      return (m > 4095) ? 4095 : m;
   endfunction

   task automatic run_frame(input int kind, input int h, input int step,
                            input bit gaps, input int limit);
      int n;
      int m;
      n = 0;
      for (int r = 0; r < H; r++) begin
         for (int c = 0; c < W; c++) begin
            if (n == limit) return;
            n++;
            gray_pixel       = 12'(pix_val(kind, h, step, r, c));
            gray_pixel_valid = 1'b1;
            @(posedge clk);
            #1;
            gray_pixel_valid = 1'b0;
            if (r >= 1 && c >= 1) begin
               m = exp_mag(kind, h, step, r - 1, c - 1);
               pulses++;
               check("valid", sobel_valid, 1);
               check("out_row", out_row, r - 1);
               check("out_col", out_col, c - 1);
               check("pixel", sobel_pixel, m);
               check("edge", sobel_edge, (m >= 256) ? 1 : 0);
            end else begin
               check("no_valid", sobel_valid, 0);
            end
            // alternate row pairs get one idle cycle after every sample
            if (gaps && ((r / 2) % 2 == 1)) begin
               @(posedge clk);
               #1;
               check("gap_valid", sobel_valid, 0);
            end
         end
      end
   endtask

   initial begin
      rst              = 1'b1;
      gray_pixel       = '0;
      gray_pixel_valid = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      check("rst_valid", sobel_valid, 0);
      check("rst_pixel", sobel_pixel, 0);
      check("rst_edge", sobel_edge, 0);
      check("rst_row", out_row, 0);
      check("rst_col", out_col, 0);
      rst = 1'b0;

      // Flat frame: (H-1)*(W-1) pulses, all zero
      pulses = 0;
      run_frame(0, 100, 0, 1'b0, W * H);
      check("flat_pulses", pulses, (H - 1) * (W - 1));

      // Vertical step 1000 at col 3 -> 4000 at centre cols 2,3
      run_frame(1, 1000, 3, 1'b0, W * H);
      // Horizontal step 4095 at row 2 -> saturates at centre rows 1,2
      run_frame(2, 4095, 2, 1'b0, W * H);
      // Same vertical step with gapped cadence; pulse count must not change
      pulses = 0;
      run_frame(1, 1000, 3, 1'b1, W * H);
      check("gap_pulses", pulses, (H - 1) * (W - 1));
      // Threshold boundary: 4*64=256 -> edge, 4*63=252 -> no edge
      run_frame(1, 64, 3, 1'b0, W * H);
      run_frame(1, 63, 3, 1'b0, W * H);

      // Mid-frame reset just after centre (1,2) produced 4000
      run_frame(1, 1000, 3, 1'b0, 2 * W + 4);
      check("pre_rst_pixel", sobel_pixel, 4000);
      rst              = 1'b1;
      gray_pixel       = 12'd999;
      gray_pixel_valid = 1'b1;
      @(posedge clk);
      #1;
      check("mid_rst_valid", sobel_valid, 0);
      check("mid_rst_pixel", sobel_pixel, 0);
      check("mid_rst_edge", sobel_edge, 0);
      check("mid_rst_row", out_row, 0);
      check("mid_rst_col", out_col, 0);
      @(posedge clk);
      #1;
      check("mid_rst_valid2", sobel_valid, 0);
      rst              = 1'b0;
      gray_pixel_valid = 1'b0;
      // Fresh frame restarts at (0,0); stale buffers are masked on borders
      run_frame(1, 1000, 3, 1'b0, W * H);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
